memwb_skid_stage: RTL and testbench
===================================

// Module: memwb_skid_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage: valid/ready handshaked register with optional skid entry, flush,
//  output-side regen gating and a WB forwarding tap. Sits between the memory stage and the register-file
//  write port. Cache misses in MEM and WB back-pressure stall it without a global stall net.
// PARAMETERS
//  WORD_W   32  width of porto, dmemload, pcplus4
//  REG_W     5  width of wsel (register index)
//  SRC_W     2  width of regsrc
//  SKID_EN   1  1: 2-entry skid (registered in_ready); 0: single register, combinational in_ready
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       asynchronous active-low reset
//  flush        in   1       synchronous squash of all held entries
//  in_valid     in   1       MEM presents a valid instruction
//  in_ready     out  1       stage accepts this cycle
//  in_porto     in   WORD_W  ALU result
//  in_dmemload  in   WORD_W  load data
//  in_pcplus4   in   WORD_W  link value for JAL
//  in_wsel      in   REG_W   destination register
//  in_regen     in   1       register write enable
//  in_regsrc    in   SRC_W   WB source select
//  in_halt      in   1       halt marker
//  out_valid    out  1       held entry valid
//  out_ready    in   1       WB consumes this cycle
//  out_wsel     out  REG_W   destination register
//  out_regen    out  1       regen AND out_valid
//  out_wdat     out  WORD_W  selected writeback data
//  out_halt     out  1       halt AND out_valid
//  fwd_en       out  1       out_valid & regen & (wsel != 0)
//  fwd_wsel     out  REG_W   = out_wsel
//  fwd_data     out  WORD_W  = out_wdat
// BEHAVIOUR
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency 1 cycle, accept to out_valid.
//  - regsrc mux: 00 porto, 01 dmemload, 10 pcplus4, 11 porto. Combinational from the main entry.
//  - SKID_EN=1 FSM: EMPTY, FULL (main valid), SKID (main + skid valid). in_ready = (state != SKID), registered.
//    EMPTY: accept -> FULL, main <= in.
//    FULL: accept & consume -> FULL, main <= in; accept & !consume -> SKID, skid <= in;
//          !accept & consume -> EMPTY; else hold.
//    SKID: consume -> FULL, main <= skid; else hold. There is no accept in SKID.
//  - SKID_EN=0: in_ready = !out_valid | out_ready. States are EMPTY/FULL only.
//  - Order is preserved: the skid entry always leaves after the main entry.
//  - flush has highest priority. state -> EMPTY next edge; a same-cycle accept is discarded.
//    in_ready is still driven per the rule above. Data registers hold stale values.
//  - Invalid entries never write: out_regen, out_halt and fwd_en are 0 whenever out_valid=0.
//  - Reset (nRST=0, async): state EMPTY, all data registers 0, out_valid=0, out_regen=0, out_halt=0,
//    fwd_en=0, in_ready=1. Reset mid-transfer drops all entries.
//  - Field widths pass through unchanged. There is no arithmetic in this stage.
// STRUCTURE
//  - cpu_types_pkg gains: memwb_t packed struct {porto, dmemload, pcplus4, wsel, regen, regsrc, halt};
//    regsrc_t enum {SRC_ALU, SRC_MEM, SRC_PC4}; skid_state_t enum {EMPTY, FULL, SKID}.
//  - Sub-module pipe_skid_buf: generic on the payload width. It holds the FSM and both registers.
//    This block wraps it with the regsrc mux and gating, and pipe_skid_buf is reused for the other stages.
// TESTING
//  1. Reset: nRST=0 for 2 cycles, inputs random -> out_valid=0, out_regen=0, fwd_en=0, in_ready=1.
//  2. Stream: 4 accepts (wsel 1..4, porto 0x10..0x40), out_ready=1 ->
//     out_wdat 0x10..0x40 on consecutive cycles, 1-cycle latency.
//  3. Skid (SKID_EN=1): out_ready=0, send A then B -> state SKID, in_ready=0 from the next edge;
//     out_ready=1 -> A, then B, no loss or duplication.
//  4. Flush in SKID with in_valid=1 -> next cycle out_valid=0 and the offered entry is dropped.
//  5. Mux and forwarding: regsrc=01 dmemload=0xDEAD, wsel=0, regen=1 -> out_wdat=0xDEAD, fwd_en=0;
//     same with wsel=8 -> fwd_en=1.
//  6. SKID_EN=0: FULL with out_ready toggling -> in_ready tracks out_ready in the same cycle, and the
//     entry is replaced on the same-edge accept+consume.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
// Stage bundles, WB source selects and skid FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int SRC_W  = 2;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC4 = 2'd2
  } regsrc_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] porto;
    logic [WORD_W-1:0] dmemload;
    logic [WORD_W-1:0] pcplus4;
    logic [REG_W-1:0]  wsel;
    logic              regen;
    logic [SRC_W-1:0]  regsrc;
    logic              halt;
  } memwb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register.
// Optional second (skid) entry keeps in_ready registered.
module pipe_skid_buf
  import cpu_types_pkg::*;
#(
  parameter int W       = 8,
  parameter int SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         accept;
  logic         consume;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = (SKID_EN != 0)
                   ? rdy_q
                   : (!out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Next state and entry moves; flush overrides all
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = SKID;
          skid_d  = in_data;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (consume) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    rdy_d = (state_d != SKID);
  end

  // State, entries and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM->WB stage: handshaked register, WB mux,
// valid gating and forwarding tap.
module memwb_skid_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int REG_W   = 5,
  parameter int SRC_W   = 2,
  parameter int SKID_EN = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_porto,
  input  logic [WORD_W-1:0] in_dmemload,
  input  logic [WORD_W-1:0] in_pcplus4,
  input  logic [REG_W-1:0]  in_wsel,
  input  logic              in_regen,
  input  logic [SRC_W-1:0]  in_regsrc,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_wsel,
  output logic              out_regen,
  output logic [WORD_W-1:0] out_wdat,
  output logic              out_halt,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_wsel,
  output logic [WORD_W-1:0] fwd_data
);

  localparam int PW = 3*WORD_W + REG_W + SRC_W + 2;

  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     out_pay;
  logic [WORD_W-1:0] m_porto;
  logic [WORD_W-1:0] m_dmem;
  logic [WORD_W-1:0] m_pc4;
  logic [REG_W-1:0]  m_wsel;
  logic              m_regen;
  logic [SRC_W-1:0]  m_regsrc;
  logic              m_halt;
  logic [WORD_W-1:0] wdat;

  assign in_pay = {in_porto, in_dmemload,
                   in_pcplus4, in_wsel, in_regen,
                   in_regsrc, in_halt};

  assign {m_porto, m_dmem, m_pc4, m_wsel,
          m_regen, m_regsrc, m_halt} = out_pay;

  pipe_skid_buf #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  // Writeback source select; 11 falls back to ALU
  always_comb begin
    wdat = m_porto;
    unique case (1'b1)
      (m_regsrc == SRC_W'(SRC_MEM)): wdat = m_dmem;
      (m_regsrc == SRC_W'(SRC_PC4)): wdat = m_pc4;
      default:                       wdat = m_porto;
    endcase
  end

  assign out_wsel  = m_wsel;
  assign out_wdat  = wdat;
  assign out_regen = m_regen & out_valid;
  assign out_halt  = m_halt & out_valid;
  assign fwd_en    = out_regen & (m_wsel != '0);
  assign fwd_wsel  = m_wsel;
  assign fwd_data  = wdat;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: skid and
// single-register instances against a queue model.
module tb_memwb_skid_stage;

  typedef struct {
    logic [4:0]  wsel;
    logic        regen;
    logic [1:0]  regsrc;
    logic        halt;
    logic [31:0] porto;
    logic [31:0] dmem;
    logic [31:0] pc4;
  } item_t;

  logic CLK = 0;
  logic nRST;
  logic flush;
  logic in_valid_a;
  logic in_valid_b;
  logic out_ready;
  item_t cur;

  logic        a_ir, a_ov, a_rg, a_ht, a_fe;
  logic [4:0]  a_ws, a_fws;
  logic [31:0] a_wd, a_fd;
  logic        b_ir, b_ov, b_rg, b_ht, b_fe;
  logic [4:0]  b_ws, b_fws;
  logic [31:0] b_wd, b_fd;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  item_t sb[$];

  always #5 CLK = ~CLK;

  memwb_skid_stage #(.SKID_EN(1)) u_a (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid_a), .in_ready(a_ir),
    .in_porto(cur.porto), .in_dmemload(cur.dmem),
    .in_pcplus4(cur.pc4), .in_wsel(cur.wsel),
    .in_regen(cur.regen), .in_regsrc(cur.regsrc),
    .in_halt(cur.halt), .out_valid(a_ov),
    .out_ready(out_ready), .out_wsel(a_ws),
    .out_regen(a_rg), .out_wdat(a_wd),
    .out_halt(a_ht), .fwd_en(a_fe),
    .fwd_wsel(a_fws), .fwd_data(a_fd)
  );

  memwb_skid_stage #(.SKID_EN(0)) u_b (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid_b), .in_ready(b_ir),
    .in_porto(cur.porto), .in_dmemload(cur.dmem),
    .in_pcplus4(cur.pc4), .in_wsel(cur.wsel),
    .in_regen(cur.regen), .in_regsrc(cur.regsrc),
    .in_halt(cur.halt), .out_valid(b_ov),
    .out_ready(out_ready), .out_wsel(b_ws),
    .out_regen(b_rg), .out_wdat(b_wd),
    .out_halt(b_ht), .fwd_en(b_fe),
    .fwd_wsel(b_fws), .fwd_data(b_fd)
  );

  function automatic logic [31:0] exp_wdat(
    input item_t e);
    case (e.regsrc)
      2'b01:   return e.dmem;
      2'b10:   return e.pc4;
      default: return e.porto;
    endcase
  endfunction

  task automatic set_item(
    input logic [4:0] ws, input logic rg,
    input logic [1:0] rs, input logic ht,
    input logic [31:0] po, input logic [31:0] dm,
    input logic [31:0] pc);
    cur.wsel = ws; cur.regen = rg;
    cur.regsrc = rs; cur.halt = ht;
    cur.porto = po; cur.dmem = dm; cur.pc4 = pc;
  endtask

  // One clock of one DUT, checked against the model
  task automatic cycle(input bit use_b);
    logic ir, ov, rg, ht, fe, iv;
    logic [4:0] ws, fws;
    logic [31:0] wd, fd;
    logic exp_ir, exp_ov;
    bit acc, con;
    item_t e;
    @(negedge CLK);
    if (use_b) begin
      ir = b_ir; ov = b_ov; rg = b_rg; ht = b_ht;
      fe = b_fe; ws = b_ws; wd = b_wd; iv = in_valid_b;
      fws = b_fws; fd = b_fd;
    end else begin
      ir = a_ir; ov = a_ov; rg = a_rg; ht = a_ht;
      fe = a_fe; ws = a_ws; wd = a_wd; iv = in_valid_a;
      fws = a_fws; fd = a_fd;
    end
    exp_ov = (sb.size() > 0);
    exp_ir = use_b ? (!exp_ov || out_ready)
                   : (sb.size() < 2);
    total++;
    if (ir !== exp_ir) begin
      bad++;
      $display("FAIL in_ready dut=%0d got=%b exp=%b",
               use_b, ir, exp_ir);
    end
    total++;
    if (ov !== exp_ov) begin
      bad++;
      $display("FAIL out_valid dut=%0d got=%b exp=%b",
               use_b, ov, exp_ov);
    end
    if (!exp_ov) begin
      total++;
      if ({rg, ht, fe} !== 3'b000) begin
        bad++;
        $display("FAIL gating dut=%0d got=%b exp=000",
                 use_b, {rg, ht, fe});
      end
    end
    acc = iv && exp_ir;
    con = exp_ov && out_ready;
    if (flush) begin
      sb.delete();
    end else begin
      if (con) begin
        e = sb.pop_front();
        pops++;
        total++;
        if (wd !== exp_wdat(e) || fd !== exp_wdat(e)) begin
          bad++;
          $display("FAIL wdat dut=%0d got=%h exp=%h",
                   use_b, wd, exp_wdat(e));
        end
        total++;
        if (ws !== e.wsel || fws !== e.wsel) begin
          bad++;
          $display("FAIL wsel dut=%0d got=%0d exp=%0d",
                   use_b, ws, e.wsel);
        end
        total++;
        if ({rg, ht, fe} !==
            {e.regen, e.halt,
             e.regen && (e.wsel != 0)}) begin
          bad++;
          $display("FAIL ctl dut=%0d got=%b exp=%b",
                   use_b, {rg, ht, fe},
                   {e.regen, e.halt,
                    e.regen && (e.wsel != 0)});
        end
      end
      if (acc) sb.push_back(cur);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input bit use_b);
    int n;
    in_valid_a = 0;
    in_valid_b = 0;
    out_ready = 1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      cycle(use_b);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d exp=0",
               sb.size());
    end
    cycle(use_b);
  endtask

  task automatic test_reset;
    nRST = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid_a = 1'($urandom);
      in_valid_b = 1'($urandom);
      out_ready  = 1'($urandom);
      set_item(5'($urandom), 1'($urandom),
               2'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom);
      @(negedge CLK);
      total++;
      if ({a_ov, a_rg, a_ht, a_fe, a_ir} !== 5'b00001) begin
        bad++;
        $display("FAIL reset_a got=%b exp=00001",
                 {a_ov, a_rg, a_ht, a_fe, a_ir});
      end
      total++;
      if ({b_ov, b_rg, b_ht, b_fe, b_ir} !== 5'b00001) begin
        bad++;
        $display("FAIL reset_b got=%b exp=00001",
                 {b_ov, b_rg, b_ht, b_fe, b_ir});
      end
    end
    in_valid_a = 0;
    in_valid_b = 0;
    out_ready  = 0;
    nRST = 1;
    sb.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_stream;
    int p0;
    p0 = pops;
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      set_item(5'(i), 1, 2'b00, 0,
               32'(i * 16), 32'hAAAA_0000, 32'h4);
      in_valid_a = 1;
      cycle(0);
    end
    in_valid_a = 0;
    cycle(0);
    total++;
    if (pops - p0 != 4 || sb.size() != 0) begin
      bad++;
      $display("FAIL stream pops=%0d exp=4",
               pops - p0);
    end
  endtask

  task automatic test_skid;
    int p0;
    p0 = pops;
    out_ready = 0;
    set_item(5'd9, 1, 2'b00, 0, 32'hA, 0, 0);
    in_valid_a = 1;
    cycle(0);
    set_item(5'd10, 1, 2'b10, 1, 0, 0, 32'hB);
    cycle(0);
    set_item(5'd11, 1, 2'b00, 0, 32'hC, 0, 0);
    cycle(0);
    cycle(0);
    in_valid_a = 0;
    out_ready = 1;
    cycle(0);
    cycle(0);
    cycle(0);
    total++;
    if (pops - p0 != 2 || sb.size() != 0) begin
      bad++;
      $display("FAIL skid_order pops=%0d exp=2",
               pops - p0);
    end
  endtask

  task automatic test_flush;
    out_ready = 0;
    set_item(5'd3, 1, 2'b00, 0, 32'h31, 0, 0);
    in_valid_a = 1;
    cycle(0);
    set_item(5'd4, 1, 2'b00, 0, 32'h41, 0, 0);
    cycle(0);
    set_item(5'd5, 1, 2'b00, 1, 32'h51, 0, 0);
    flush = 1;
    cycle(0);
    flush = 0;
    in_valid_a = 0;
    out_ready = 1;
    cycle(0);
    out_ready = 0;
    set_item(5'd6, 1, 2'b00, 0, 32'h61, 0, 0);
    in_valid_a = 1;
    cycle(0);
    set_item(5'd7, 1, 2'b00, 0, 32'h71, 0, 0);
    flush = 1;
    cycle(0);
    flush = 0;
    in_valid_a = 0;
    out_ready = 1;
    cycle(0);
    cycle(0);
  endtask

  task automatic test_mux_fwd;
    out_ready = 1;
    in_valid_a = 1;
    set_item(5'd0, 1, 2'b01, 0,
             32'h1111, 32'hDEAD, 32'h2222);
    cycle(0);
    set_item(5'd8, 1, 2'b01, 0,
             32'h1111, 32'hDEAD, 32'h2222);
    cycle(0);
    set_item(5'd12, 1, 2'b10, 0,
             32'h1111, 32'hDEAD, 32'h2222);
    cycle(0);
    set_item(5'd13, 0, 2'b11, 0,
             32'h1111, 32'hDEAD, 32'h2222);
    cycle(0);
    drain(0);
  endtask

  task automatic test_noskid;
    int p0;
    p0 = pops;
    out_ready = 0;
    set_item(5'd20, 1, 2'b00, 0, 32'hA0, 0, 0);
    in_valid_b = 1;
    cycle(1);
    set_item(5'd21, 1, 2'b00, 0, 32'hA1, 0, 0);
    cycle(1);
    out_ready = 1;
    cycle(1);
    out_ready = 0;
    set_item(5'd22, 1, 2'b00, 0, 32'hA2, 0, 0);
    cycle(1);
    out_ready = 1;
    cycle(1);
    in_valid_b = 0;
    cycle(1);
    cycle(1);
    total++;
    if (pops - p0 != 3 || sb.size() != 0) begin
      bad++;
      $display("FAIL noskid_pops got=%0d exp=3",
               pops - p0);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    set_item(5'd15, 1, 2'b00, 1, 32'hF, 0, 0);
    in_valid_a = 1;
    cycle(0);
    cycle(0);
    in_valid_a = 0;
    @(negedge CLK);
    nRST = 0;
    #1;
    total++;
    if ({a_ov, a_rg, a_ht, a_fe, a_ir} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=00001",
               {a_ov, a_rg, a_ht, a_fe, a_ir});
    end
    sb.delete();
    #2;
    nRST = 1;
    @(posedge CLK);
    #1;
    out_ready = 1;
    cycle(0);
  endtask

  initial begin
    nRST = 0;
    flush = 0;
    in_valid_a = 0;
    in_valid_b = 0;
    out_ready = 0;
    set_item(0, 0, 0, 0, 0, 0, 0);
    test_reset;
    test_stream;
    test_skid;
    test_flush;
    test_mux_fwd;
    test_noskid;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
